// File: rtl/br_result_update_queue_pkg.sv
// br_result_update_queue_pkg: FetchUnitTypes, the branch-update types, sizes and PHT index function
package FetchUnitTypes;
  localparam int BR_UPDATE_QUEUE_DEPTH = 8;
  localparam int BR_UPDATE_LANES = 2;
  localparam int PHT_IDX_W = 8;
  localparam int PHT_BANK_W = 1;
  localparam int INSN_ADDR_SH = 2;
  localparam int ADDR_W = 32;
  typedef logic [$clog2(BR_UPDATE_QUEUE_DEPTH)-1:0] BrUpdateQueuePtr;
  typedef logic [PHT_IDX_W-1:0] PhtIndex;
  typedef logic [PHT_BANK_W-1:0] PhtBank;
  typedef struct packed {
    logic [ADDR_W-1:0] brAddr;
    logic execTaken;
    logic isCondBr;
    logic mispred;
    logic [1:0] phtPrevValue;
  } BrUpdateEntry;
  function automatic PhtIndex BrUpdateIndex(logic [ADDR_W-1:0] addr);
    return PhtIndex'(addr >> INSN_ADDR_SH);
  endfunction
  function automatic PhtBank BrUpdateBank(PhtIndex idx);
    return PhtBank'(idx);
  endfunction
endpackage

// File: rtl/br_result_update_queue_bank_arbiter.sv
// br_update_bank_arbiter: in-order issue mask; a slot issues only if all older slots issue on other banks
module br_update_bank_arbiter
  import FetchUnitTypes::*;
#(
  parameter int LANES = BR_UPDATE_LANES
) (
  input  logic [LANES-1:0] candValid,
  input  PhtBank           candBank [LANES],
  output logic [LANES-1:0] issue
);
  logic ok;
  always_comb begin
    issue = '0;
    ok = 1'b1;
    for (int s = 0; s < LANES; s++) begin
      issue[s] = ok && candValid[s];
      for (int p = 0; p < s; p++) issue[s] = issue[s] && candBank[p] != candBank[s];
      ok = issue[s];
    end
  end
endmodule

// File: rtl/br_result_update_queue.sv
// br_result_update_queue: in-order branch-result buffer issuing bank-disjoint PHT updates.
// Optional same-cycle bypass of an empty queue with macro BR_UPDATE_BYPASS_EN.
module br_result_update_queue
  import FetchUnitTypes::*;
#(
  parameter int LANES = BR_UPDATE_LANES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] inValid,
  input  BrUpdateEntry     inEntry [LANES],
  input  logic             predBusy,
  output logic             stallIssue,
  output logic [LANES-1:0] outValid,
  output BrUpdateEntry     outEntry [LANES],
  output PhtIndex          outIdx [LANES],
  output logic             overflow
);
  localparam int DEPTH = BR_UPDATE_QUEUE_DEPTH;
  localparam int CW = $clog2(DEPTH) + 1;
  BrUpdateEntry q [DEPTH];
  BrUpdateEntry packedIn [LANES], enqEntry [LANES], candEntry [LANES];
  PhtBank candBank [LANES];
  BrUpdateQueuePtr head, tail;
  logic [CW-1:0] count, countNext, nIn, nIssued, nByp, nDeq, nWant, nEnq, free;
  logic [LANES-1:0] candValid;
  logic bypass, drop;
`ifdef BR_UPDATE_BYPASS_EN
  assign bypass = count == '0 && !predBusy;
`else
  assign bypass = 1'b0;
`endif
  // compact valid lanes so lane 0 (oldest) lands first
  always_comb begin
    nIn = '0;
    for (int k = 0; k < LANES; k++) packedIn[k] = inEntry[k];
    for (int l = 0; l < LANES; l++) begin
      for (int k = 0; k < LANES; k++) if (inValid[l] && nIn == CW'(k)) packedIn[k] = inEntry[l];
      nIn = nIn + CW'(inValid[l]);
    end
  end
  always_comb begin
    for (int s = 0; s < LANES; s++) begin
      candValid[s] = bypass ? nIn > CW'(s) : !predBusy && count > CW'(s);
      candEntry[s] = bypass ? packedIn[s] : q[head + BrUpdateQueuePtr'(s)];
      candBank[s] = BrUpdateBank(BrUpdateIndex(candEntry[s].brAddr));
      outEntry[s] = candEntry[s];
      outIdx[s] = BrUpdateIndex(candEntry[s].brAddr);
    end
  end
  br_update_bank_arbiter #(.LANES(LANES)) arb (
    .candValid(candValid),
    .candBank(candBank),
    .issue(outValid)
  );
  // lanes blocked in bypass fall back to the queue, shifted past the bypassed ones
  always_comb begin
    nIssued = '0;
    for (int s = 0; s < LANES; s++) nIssued = nIssued + CW'(outValid[s]);
    nByp = bypass ? nIssued : '0;
    nDeq = bypass ? '0 : nIssued;
    nWant = nIn - nByp;
    free = CW'(DEPTH) - count;
    drop = nWant > free;
    nEnq = drop ? free : nWant;
    countNext = count + nEnq - nDeq;
    for (int k = 0; k < LANES; k++) begin
      enqEntry[k] = packedIn[k];
      for (int j = 1; j < LANES; j++) if (nByp == CW'(j)) enqEntry[k] = packedIn[(k + j) % LANES];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      overflow <= 1'b0;
      stallIssue <= 1'b0;
    end else begin
      head <= head + BrUpdateQueuePtr'(nDeq);
      tail <= tail + BrUpdateQueuePtr'(nEnq);
      count <= countNext;
      overflow <= overflow | drop;
      stallIssue <= (CW'(DEPTH) - countNext) < CW'(LANES);
    end
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < LANES; k++) if (CW'(k) < nEnq) q[tail + BrUpdateQueuePtr'(k)] <= enqEntry[k];
    if (!rst) assert (!drop) else $warning("br_result_update_queue: input presented while full, entry dropped");
  end
endmodule

// File: tb/tb_br_result_update_queue.sv
// tb_br_result_update_queue: vector table plus scoreboard, reset and bypass sequences
module tb_br_result_update_queue;
  import FetchUnitTypes::*;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] inValid, outValid;
  BrUpdateEntry inEntry [2];
  BrUpdateEntry outEntry [2];
  PhtIndex outIdx [2];
  logic predBusy, stallIssue, overflow;
  int total = 0;
  int bad = 0;

  br_result_update_queue dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inEntry(inEntry), .predBusy(predBusy),
    .stallIssue(stallIssue), .outValid(outValid), .outEntry(outEntry), .outIdx(outIdx),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] vin;
    PhtIndex a, b;
    logic busy;
    logic [1:0] ev;
    PhtIndex e0, e1;
    int cnt;
    logic st, ov;
  } vec_t;
  vec_t vecs [16];

  function automatic BrUpdateEntry mk(PhtIndex i);
    BrUpdateEntry e;
    e.brAddr = {22'h2a5, i, 2'b00};
    e.execTaken = i[1];
    e.isCondBr = i[2];
    e.mispred = i[3];
    e.phtPrevValue = i[5:4];
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [1:0] v, PhtIndex a, PhtIndex b, logic busy);
    inValid = v;
    inEntry[0] = mk(a);
    inEntry[1] = mk(b);
    predBusy = busy;
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    drive(2'b00, 8'h0, 8'h0, 1'b0);
    #3;
    chk("reset outValid", 64'(outValid), 64'(0));
    chk("reset count", 64'(dut.count), 64'(0));
    chk("reset stall", 64'(stallIssue), 64'(0));
    chk("reset overflow", 64'(overflow), 64'(0));
    rst = 1'b0;
    tick;
  endtask

  initial begin
    vecs = '{
      '{2'b11, 8'h10, 8'h11, 1'b0, 2'b00, 8'h00, 8'h00, 2, 1'b0, 1'b0},
      '{2'b00, 8'h00, 8'h00, 1'b0, 2'b11, 8'h10, 8'h11, 0, 1'b0, 1'b0},
      '{2'b11, 8'h10, 8'h12, 1'b0, 2'b00, 8'h00, 8'h00, 2, 1'b0, 1'b0},
      '{2'b00, 8'h00, 8'h00, 1'b0, 2'b01, 8'h10, 8'h00, 1, 1'b0, 1'b0},
      '{2'b00, 8'h00, 8'h00, 1'b0, 2'b01, 8'h12, 8'h00, 0, 1'b0, 1'b0},
      '{2'b11, 8'h30, 8'h31, 1'b1, 2'b00, 8'h00, 8'h00, 2, 1'b0, 1'b0},
      '{2'b11, 8'h32, 8'h33, 1'b1, 2'b00, 8'h00, 8'h00, 4, 1'b0, 1'b0},
      '{2'b11, 8'h34, 8'h35, 1'b1, 2'b00, 8'h00, 8'h00, 6, 1'b0, 1'b0},
      '{2'b01, 8'h36, 8'h00, 1'b1, 2'b00, 8'h00, 8'h00, 7, 1'b1, 1'b0},
      '{2'b11, 8'h37, 8'h38, 1'b1, 2'b00, 8'h00, 8'h00, 8, 1'b1, 1'b1},
      '{2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 8'h00, 8'h00, 8, 1'b1, 1'b1},
      '{2'b00, 8'h00, 8'h00, 1'b0, 2'b11, 8'h30, 8'h31, 6, 1'b0, 1'b1},
      '{2'b00, 8'h00, 8'h00, 1'b0, 2'b11, 8'h32, 8'h33, 4, 1'b0, 1'b1},
      '{2'b00, 8'h00, 8'h00, 1'b0, 2'b11, 8'h34, 8'h35, 2, 1'b0, 1'b1},
      '{2'b00, 8'h00, 8'h00, 1'b0, 2'b11, 8'h36, 8'h37, 0, 1'b0, 1'b1},
      '{2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00, 0, 1'b0, 1'b1}
    };
    do_reset;
`ifndef BR_UPDATE_BYPASS_EN
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].vin, vecs[i].a, vecs[i].b, vecs[i].busy);
      chk($sformatf("v%0d outValid", i), 64'(outValid), 64'(vecs[i].ev));
      if (vecs[i].ev[0]) begin
        chk($sformatf("v%0d idx0", i), 64'(outIdx[0]), 64'(vecs[i].e0));
        chk($sformatf("v%0d entry0", i), 64'(outEntry[0]), 64'(mk(vecs[i].e0)));
      end
      if (vecs[i].ev[1]) begin
        chk($sformatf("v%0d idx1", i), 64'(outIdx[1]), 64'(vecs[i].e1));
        chk($sformatf("v%0d entry1", i), 64'(outEntry[1]), 64'(mk(vecs[i].e1)));
      end
      tick;
      chk($sformatf("v%0d count", i), 64'(dut.count), 64'(vecs[i].cnt));
      chk($sformatf("v%0d stall", i), 64'(stallIssue), 64'(vecs[i].st));
      chk($sformatf("v%0d overflow", i), 64'(overflow), 64'(vecs[i].ov));
    end
    do_reset;
    begin
      PhtIndex model[$];
      for (int c = 0; c < 20; c++) begin
        logic busy;
        logic [1:0] v, ev;
        PhtIndex a, b;
        busy = $urandom_range(0, 3) == 0;
        v = model.size() <= 4 ? 2'($urandom_range(0, 3)) : 2'b00;
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
        drive(v, a, b, busy);
        ev = 2'b00;
        if (!busy && model.size() >= 1) ev[0] = 1'b1;
        if (ev[0] && model.size() >= 2 && model[0][0] != model[1][0]) ev[1] = 1'b1;
        chk($sformatf("sb%0d outValid", c), 64'(outValid), 64'(ev));
        if (ev[0]) chk($sformatf("sb%0d idx0", c), 64'(outIdx[0]), 64'(model[0]));
        if (ev[1]) chk($sformatf("sb%0d idx1", c), 64'(outIdx[1]), 64'(model[1]));
        tick;
        repeat (int'(ev[0]) + int'(ev[1])) void'(model.pop_front());
        if (v[0]) model.push_back(a);
        if (v[1]) model.push_back(b);
        chk($sformatf("sb%0d count", c), 64'(dut.count), 64'(model.size()));
      end
    end
    drive(2'b11, 8'h40, 8'h41, 1'b1);
    tick;
    drive(2'b00, 8'h00, 8'h00, 1'b0);
    chk("pre-reset outValid", 64'(outValid), 64'(2'b11));
    #2 rst = 1'b1;
    #1;
    chk("mid-reset outValid", 64'(outValid), 64'(0));
    chk("mid-reset count", 64'(dut.count), 64'(0));
    #1 rst = 1'b0;
    tick;
    chk("post-reset outValid", 64'(outValid), 64'(0));
`else
    drive(2'b11, 8'h20, 8'h21, 1'b0);
    chk("byp outValid", 64'(outValid), 64'(2'b11));
    chk("byp idx0", 64'(outIdx[0]), 64'(8'h20));
    chk("byp idx1", 64'(outIdx[1]), 64'(8'h21));
    chk("byp entry1", 64'(outEntry[1]), 64'(mk(8'h21)));
    tick;
    chk("byp count", 64'(dut.count), 64'(0));
    drive(2'b11, 8'h20, 8'h22, 1'b0);
    chk("bypc outValid", 64'(outValid), 64'(2'b01));
    chk("bypc idx0", 64'(outIdx[0]), 64'(8'h20));
    tick;
    chk("bypc count", 64'(dut.count), 64'(1));
    drive(2'b00, 8'h00, 8'h00, 1'b0);
    chk("bypc2 outValid", 64'(outValid), 64'(2'b01));
    chk("bypc2 idx0", 64'(outIdx[0]), 64'(8'h22));
    tick;
    chk("bypc2 count", 64'(dut.count), 64'(0));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
